// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared mode encodings for the toggle flip-flop counter
package tff_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_TOG  = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DN   = 2'b11;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - one negedge toggle flip-flop with preset/clear/load priority
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic pre,
  input  logic clr,
  input  logic load,
  input  logic d,
  input  logic tog,
  output logic q
);

  logic r_q;

  // Falling-edge flop: reset > preset > clear > load > toggle
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= rst_val;
    end else if (pre) begin
      r_q <= 1'b1;
    end else if (clr) begin
      r_q <= 1'b0;
    end else if (load) begin
      r_q <= d;
    end else if (tog) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule : tff_cell

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - WIDTH-bit toggle flop bank with load, mask toggle and up/down count
module tff_counter
  import tff_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               SATURATE = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             sat
);

  // w_all1[i] / w_all0[i]: every bit below i is one / zero (bit 0 sees an empty prefix)
  logic [WIDTH-1:0] w_all1;
  logic [WIDTH-1:0] w_all0;
  logic [WIDTH-1:0] w_tog;
  logic             w_full1;
  logic             w_full0;
  logic             w_up;
  logic             w_dn;
  logic             w_tgl;
  logic             w_term;
  logic             w_hold_sat;
  logic             w_sync;
  logic             r_tc;
  logic             r_sat;

  assign w_all1[0] = 1'b1;
  assign w_all0[0] = 1'b1;

  genvar i;
  for (i = 1; i < WIDTH; i++) begin : g_chain
    assign w_all1[i] = w_all1[i-1] & q[i-1];
    assign w_all0[i] = w_all0[i-1] & ~q[i-1];
  end

  assign w_full1 = w_all1[WIDTH-1] & q[WIDTH-1];
  assign w_full0 = w_all0[WIDTH-1] & ~q[WIDTH-1];

  assign w_up  = en && (mode == MODE_UP);
  assign w_dn  = en && (mode == MODE_DN);
  assign w_tgl = en && (mode == MODE_TOG);

  // Terminal condition: counting past all-ones upward or past zero downward
  assign w_term     = (w_up && w_full1) || (w_dn && w_full0);
  // In saturating builds the terminal count freezes every bit instead of wrapping
  assign w_hold_sat = (SATURATE != 0) && w_term;
  assign w_sync     = pre | clr | load;

  for (i = 0; i < WIDTH; i++) begin : g_cell
    assign w_tog[i] = (w_tgl & t[i]) |
                      (~w_hold_sat & ((w_up & w_all1[i]) | (w_dn & w_all0[i])));

    tff_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (RST_VAL[i]),
      .pre     (pre),
      .clr     (clr),
      .load    (load),
      .d       (din[i]),
      .tog     (w_tog[i]),
      .q       (q[i])
    );
  end

  // Terminal-count pulse and sticky saturation flag; synchronous ops suppress tc
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tc  <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_tc <= !w_sync && w_term;
      if (!pre && (clr || load)) begin
        r_sat <= 1'b0;
      end else if (!w_sync && w_hold_sat) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign tc  = r_tc;
  assign sat = (SATURATE != 0) && r_sat;

endmodule : tff_counter

// File: doc/tff_counter.md
# tff_counter

Parametrised bank of WIDTH toggle flip-flops with synchronous preset/clear, parallel load, per-bit toggle mask, and up/down counting built from the toggle equation. It succeeds the single-bit T/D flop. It is the standard register and counter primitive for timer, divider and pattern-generator blocks. Like the existing flops, it updates on the falling edge of the clock.

## Interface
Parameters:
- WIDTH, 8, number of bits in q (≥2)
- SATURATE, 0, 0 = count wraps; 1 = count holds at all-ones (up) or zero (down)
- RST_VAL, 0, WIDTH-bit value loaded by asynchronous reset

Ports:
- clk  in  1  clock; all state changes on negedge clk
- rst_n  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- pre  in  1  synchronous preset: q ← all ones
- clr  in  1  synchronous clear: q ← 0
- load  in  1  synchronous parallel load: q ← din
- din  in  WIDTH  load data
- en  in  1  enables the mode operation (not pre/clr/load)
- mode  in  2  00 hold, 01 toggle-mask, 10 count up, 11 count down
- t  in  WIDTH  toggle mask for mode 01 (bit i set → q[i] inverts)
- q  out  WIDTH  register value
- tc  out  1  terminal-count pulse, registered
- sat  out  1  sticky saturation flag (SATURATE=1 only, else tied 0)

## Operation
- Priority per falling edge, highest first: rst_n low > pre > clr > load > en-qualified mode.
- pre and clr together: pre wins (q = all ones).
- Hold (00) or en=0: q unchanged.
- Toggle-mask (01): q ← q ^ t.
- Count up (10): bit i toggles iff q[i-1:0] all ones; bit 0 always toggles. Equals q+1 mod 2^WIDTH.
- Count down (11): bit i toggles iff q[i-1:0] all zeros. Equals q−1 mod 2^WIDTH.
- Wrap, SATURATE=0:
  - up from all-ones → 0 with tc=1 for one cycle.
  - down from 0 → all-ones with tc=1.
- SATURATE=1:
  - up at all-ones, or down at 0: q holds, tc=1, sat set.
  - sat clears only on rst_n, clr or load.
- tc is 0 on every edge that does not perform a wrapping or saturating count, including pre/clr/load edges.
- Reset values: q=RST_VAL, tc=0, sat=0.

## Timing
- Single-cycle latency: inputs are sampled on negedge clk; q, tc and sat are valid after that edge.
- No combinational path from inputs to outputs.
- rst_n assertion clears state immediately, independent of clk. Deassertion must meet recovery/removal to negedge clk. The first operation occurs on the first falling edge with rst_n high.
- Reset mid-count: q jumps to RST_VAL at once. A tc pulse in flight is dropped.
- tc is high for exactly one clock period (negedge to negedge). Back-to-back saturating attempts give tc high continuously.
- Changing mode between edges has no effect until the next edge.

## Structure
- Shared package tff_pkg holds:
  - mode localparams: MODE_HOLD=2'b00, MODE_TOG=2'b01, MODE_UP=2'b10, MODE_DN=2'b11.
- Sub-module tff_cell (one bit):
  - inputs: clk, rst_n, rst_val, pre, clr, load, d, tog; output q.
  - Implements the negedge flop with the same priority.
  - tff_counter generates WIDTH instances and computes each tog from mode, t, and the prefix all-ones/all-zeros chains.
  - Saturation gating, tc and sat live in the top level.

## Test plan
- Reset: rst_n low mid-cycle with RST_VAL=8'h5A → q=8'h5A, tc=0, sat=0 before the next edge.
- Count up, WIDTH=8, SATURATE=0, en=1, from 8'hFE → 8'hFF then 8'h00 with tc=1 on the wrap edge only.
- Count down, SATURATE=1, from 8'h01 → 8'h00, then 8'h00 held, tc=1 and sat=1; load 8'h10 → q=8'h10, sat=0.
- Toggle-mask: q=8'h0F, t=8'hAA, mode 01 → 8'hA5; en=0 same stimulus → q unchanged.
- Priority: pre=clr=load=1, mode up → q=8'hFF, tc=0; clr=load=1 → q=0; load only with din=8'h3C → 8'h3C.
- Random mode/en/t/load sequences against a behavioural model for 10k cycles, WIDTH ∈ {2,8,17}.
